uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 149 ++++++++++++++
 tb/tb_uart_tx.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter with a holding/shift double buffer, optional parity and
// 1..4 stop bits; bit timing comes from the clk_tx rising edges seen in i_clk.
module uart_tx #(
    parameter int WIDTH_DATA = 8,
    parameter int NB_STOP    = 2,
    parameter int PARITY     = 0
) (
    input  logic                  i_clk,
    input  logic                  i_nrst,
    input  logic                  clk_tx,
    input  logic [WIDTH_DATA-1:0] i_data,
    input  logic                  i_we,
    output logic                  o_rdy,
    output logic                  o_busy,
    output logic                  o_srst_clk,
    output logic                  o_buf
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_PAR   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;

    // One counter walks both the data bits and the stop bits.
    localparam int              MAX_CNT   = (WIDTH_DATA > NB_STOP) ? WIDTH_DATA : NB_STOP;
    localparam int              CW        = $clog2(MAX_CNT + 1);
    localparam logic [CW-1:0]   LAST_DATA = CW'(WIDTH_DATA - 1);
    localparam logic [CW-1:0]   LAST_STOP = CW'(NB_STOP - 1);

    logic [1:0]            r_sync;
    logic [2:0]            r_state;
    logic [CW-1:0]         r_cnt;
    logic [WIDTH_DATA-1:0] r_thr;
    logic [WIDTH_DATA-1:0] r_tsr;
    logic                  r_par;
    logic                  r_rdy;
    logic                  r_srst;
    logic                  r_buf;

    logic                  w_ev;
    logic                  w_load;
    logic                  w_shift;
    logic [2:0]            w_state_nxt;
    logic [CW-1:0]         w_cnt_nxt;

    assign w_ev = r_sync[0] & ~r_sync[1];

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!r_rdy) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_ev) begin
                    w_state_nxt = S_DATA;
                    w_cnt_nxt   = '0;
                end
            end
            S_DATA: begin
                if (w_ev) begin
                    w_shift = 1'b1;
                    if (r_cnt == LAST_DATA) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = (PARITY != 0) ? S_PAR : S_STOP;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            S_PAR: begin
                if (w_ev) begin
                    w_state_nxt = S_STOP;
                    w_cnt_nxt   = '0;
                end
            end
            S_STOP: begin
                if (w_ev) begin
                    if (r_cnt != LAST_STOP) begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end else if (!r_rdy) begin
                        // Next word already waiting: start it with no idle bit.
                        w_load      = 1'b1;
                        w_state_nxt = S_START;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so all
    // registers see pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_sync  <= 2'b00;
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_thr   <= '1;
            r_tsr   <= '1;
            r_par   <= 1'b0;
            r_rdy   <= 1'b1;
            r_srst  <= 1'b0;
            r_buf   <= 1'b1;
        end else begin
            r_sync  <= {r_sync[0], clk_tx};
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_srst  <= w_load;

            if (w_load) begin
                r_tsr <= r_thr;
                r_par <= (PARITY == 2) ? ~^r_thr : ^r_thr;
                r_rdy <= 1'b1;
            end else begin
                if (w_shift) begin
                    r_tsr <= r_tsr >> 1;
                end
                if (i_we && r_rdy) begin
                    r_thr <= i_data;
                    r_rdy <= 1'b0;
                end
            end

            case (r_state)
                S_START: r_buf <= 1'b0;
                S_DATA:  r_buf <= r_tsr[0];
                S_PAR:   r_buf <= r_par;
                default: r_buf <= 1'b1;
            endcase
        end
    end

    assign o_rdy      = r_rdy;
    assign o_busy     = (r_state != S_IDLE);
    assign o_srst_clk = r_srst;
    assign o_buf      = r_buf;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: three instances (no parity, even, odd) sharing
// clocks and data, each with its own write strobe; o_buf sampled on clk_tx rises.
module tb_uart_tx;

    logic       i_clk  = 1'b0;
    logic       clk_tx = 1'b0;
    logic       tx_run = 1'b1;
    logic       i_nrst;
    logic [7:0] i_data;
    logic [2:0] we;
    logic [2:0] rdy, busy, srst, obuf;

    int checks   = 0;
    int errors   = 0;
    int srst_cnt = 0;
    int div      = 0;

    uart_tx #(.WIDTH_DATA(8), .NB_STOP(2), .PARITY(0)) u_dut0 (
        .i_clk(i_clk), .i_nrst(i_nrst), .clk_tx(clk_tx), .i_data(i_data), .i_we(we[0]),
        .o_rdy(rdy[0]), .o_busy(busy[0]), .o_srst_clk(srst[0]), .o_buf(obuf[0]));
    uart_tx #(.WIDTH_DATA(8), .NB_STOP(2), .PARITY(1)) u_dut1 (
        .i_clk(i_clk), .i_nrst(i_nrst), .clk_tx(clk_tx), .i_data(i_data), .i_we(we[1]),
        .o_rdy(rdy[1]), .o_busy(busy[1]), .o_srst_clk(srst[1]), .o_buf(obuf[1]));
    uart_tx #(.WIDTH_DATA(8), .NB_STOP(2), .PARITY(2)) u_dut2 (
        .i_clk(i_clk), .i_nrst(i_nrst), .clk_tx(clk_tx), .i_data(i_data), .i_we(we[2]),
        .o_rdy(rdy[2]), .o_busy(busy[2]), .o_srst_clk(srst[2]), .o_buf(obuf[2]));

    always #5 i_clk = ~i_clk;

    // Bit clock: 16 i_clk periods, toggled just after an i_clk falling edge.
    always @(negedge i_clk) begin
        if (tx_run) begin
            if (div == 7) begin
                div = 0;
                clk_tx = ~clk_tx;
            end else begin
                div++;
            end
        end
    end

    always @(negedge i_clk) if (srst[0]) srst_cnt++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic write_word(input logic [2:0] sel, input logic [7:0] d, input bit align);
        if (align) @(negedge clk_tx);
        i_data = d;
        we     = sel;
        @(negedge i_clk);
        we     = 3'b000;
    endtask

    task automatic capture(input int n, output logic [31:0] b0, output logic [31:0] b1,
                           output logic [31:0] b2);
        b0 = '0;
        b1 = '0;
        b2 = '0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk_tx);
            #1;
            b0[i] = obuf[0];
            b1[i] = obuf[1];
            b2[i] = obuf[2];
        end
    endtask

    task automatic test_reset;
        i_nrst = 1'b0;
        i_data = 8'h00;
        we     = 3'b000;
        repeat (3) @(negedge i_clk);
        checks++; if (obuf !== 3'b111) begin errors++; $display("FAIL reset_buf got %b want 111", obuf); end
        checks++; if (rdy !== 3'b111) begin errors++; $display("FAIL reset_rdy got %b want 111", rdy); end
        checks++; if (busy !== 3'b000) begin errors++; $display("FAIL reset_busy got %b want 000", busy); end
        checks++; if (srst !== 3'b000) begin errors++; $display("FAIL reset_srst got %b want 000", srst); end
        we = 3'b111;
        @(negedge i_clk);
        we = 3'b000;
        checks++; if (rdy !== 3'b111) begin errors++; $display("FAIL reset_we_ignored rdy got %b want 111", rdy); end
        i_nrst = 1'b1;
        repeat (3) @(negedge i_clk);
        checks++; if (busy !== 3'b000) begin errors++; $display("FAIL post_reset_busy got %b want 000", busy); end
    endtask

    task automatic test_frame_p0;
        logic [31:0] b0, b1, b2;
        int s0;
        s0 = srst_cnt;
        write_word(3'b001, 8'hA5, 1'b1);
        checks++; if (rdy[0] !== 1'b0) begin errors++; $display("FAIL p0_rdy_after_write got %b want 0", rdy[0]); end
        capture(12, b0, b1, b2);
        // start, 1,0,1,0,0,1,0,1, stop, stop, idle (LSB = first sample)
        checks++; if (b0[11:0] !== 12'b1_11101001010) begin
            errors++; $display("FAIL p0_frame_A5 got %b want 111101001010", b0[11:0]);
        end
        checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL p0_busy_end got %b want 0", busy[0]); end
        checks++; if (srst_cnt - s0 != 1) begin errors++; $display("FAIL p0_srst_pulses got %0d want 1", srst_cnt - s0); end
    endtask

    task automatic test_parity;
        logic [31:0] b0, b1, b2;
        write_word(3'b110, 8'hA5, 1'b1);
        capture(13, b0, b1, b2);
        checks++; if (b1[12:0] !== {1'b1, 2'b11, 1'b0, 8'hA5, 1'b0}) begin
            errors++; $display("FAIL even_A5 got %b want %b", b1[12:0], {1'b1, 2'b11, 1'b0, 8'hA5, 1'b0});
        end
        checks++; if (b2[12:0] !== {1'b1, 2'b11, 1'b1, 8'hA5, 1'b0}) begin
            errors++; $display("FAIL odd_A5 got %b want %b", b2[12:0], {1'b1, 2'b11, 1'b1, 8'hA5, 1'b0});
        end
        checks++; if (b0[12:0] !== 13'h1FFF) begin
            errors++; $display("FAIL unwritten_line got %b want all ones", b0[12:0]);
        end
        write_word(3'b010, 8'h01, 1'b1);
        capture(13, b0, b1, b2);
        checks++; if (b1[12:0] !== {1'b1, 2'b11, 1'b1, 8'h01, 1'b0}) begin
            errors++; $display("FAIL even_01 got %b want %b", b1[12:0], {1'b1, 2'b11, 1'b1, 8'h01, 1'b0});
        end
        checks++; if (busy !== 3'b000) begin errors++; $display("FAIL parity_busy_end got %b want 000", busy); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] b0, b1, b2;
        logic [31:0] c0, c1, c2;
        int s0;
        s0 = srst_cnt;
        write_word(3'b001, 8'h55, 1'b1);
        @(negedge i_clk);
        write_word(3'b001, 8'h0F, 1'b0);
        checks++; if (rdy[0] !== 1'b0) begin errors++; $display("FAIL b2b_rdy_thr_full got %b want 0", rdy[0]); end
        write_word(3'b001, 8'hAA, 1'b0);
        checks++; if (rdy[0] !== 1'b0) begin errors++; $display("FAIL b2b_rdy_after_third got %b want 0", rdy[0]); end
        capture(10, b0, b1, b2);
        checks++; if (rdy[0] !== 1'b0) begin errors++; $display("FAIL b2b_rdy_first_stop got %b want 0", rdy[0]); end
        checks++; if (b0[9:0] !== {1'b1, 8'h55, 1'b0}) begin
            errors++; $display("FAIL b2b_frame1 got %b want %b", b0[9:0], {1'b1, 8'h55, 1'b0});
        end
        capture(14, c0, c1, c2);
        checks++; if (c0[13:0] !== {2'b11, 2'b11, 8'h0F, 1'b0, 1'b1}) begin
            errors++; $display("FAIL b2b_frame2 got %b want %b", c0[13:0], {2'b11, 2'b11, 8'h0F, 1'b0, 1'b1});
        end
        checks++; if (rdy[0] !== 1'b1 || busy[0] !== 1'b0) begin
            errors++; $display("FAIL b2b_end rdy/busy got %b%b want 10", rdy[0], busy[0]);
        end
        checks++; if (srst_cnt - s0 != 2) begin errors++; $display("FAIL b2b_srst_pulses got %0d want 2", srst_cnt - s0); end
    endtask

    task automatic test_reset_mid_frame;
        logic [31:0] b0, b1, b2;
        write_word(3'b001, 8'hA5, 1'b1);
        @(negedge i_clk);
        write_word(3'b001, 8'hFF, 1'b0);
        capture(5, b0, b1, b2);
        checks++; if (b0[4:0] !== 5'b01010) begin errors++; $display("FAIL mid_prefix got %b want 01010", b0[4:0]); end
        checks++; if (busy[0] !== 1'b1 || rdy[0] !== 1'b0) begin
            errors++; $display("FAIL mid_pre_reset busy/rdy got %b%b want 10", busy[0], rdy[0]);
        end
        i_nrst = 1'b0;
        #1;
        checks++; if (obuf[0] !== 1'b1) begin errors++; $display("FAIL mid_reset_buf got %b want 1", obuf[0]); end
        checks++; if (rdy[0] !== 1'b1) begin errors++; $display("FAIL mid_reset_rdy got %b want 1", rdy[0]); end
        checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL mid_reset_busy got %b want 0", busy[0]); end
        @(negedge i_clk);
        i_nrst = 1'b1;
        write_word(3'b001, 8'h3C, 1'b1);
        capture(13, b0, b1, b2);
        checks++; if (b0[12:0] !== {2'b11, 2'b11, 8'h3C, 1'b0}) begin
            errors++; $display("FAIL post_reset_frame got %b want %b", b0[12:0], {2'b11, 2'b11, 8'h3C, 1'b0});
        end
        checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL post_reset_busy got %b want 0", busy[0]); end
    endtask

    task automatic test_stall;
        logic [31:0] b0, b1, b2;
        logic        v;
        int          bad;
        write_word(3'b001, 8'hC3, 1'b1);
        capture(4, b0, b1, b2);
        checks++; if (b0[3:0] !== 4'b0110) begin errors++; $display("FAIL stall_prefix got %b want 0110", b0[3:0]); end
        tx_run = 1'b0;
        v   = obuf[0];
        bad = 0;
        repeat (1000) begin
            @(negedge i_clk);
            if (obuf[0] !== v || busy[0] !== 1'b1) bad++;
        end
        checks++; if (v !== 1'b0) begin errors++; $display("FAIL stall_bit2 got %b want 0", v); end
        checks++; if (bad != 0) begin errors++; $display("FAIL stall_hold changes %0d want 0", bad); end
        tx_run = 1'b1;
        capture(8, b0, b1, b2);
        checks++; if (b0[7:0] !== {1'b1, 2'b11, 5'b11000}) begin
            errors++; $display("FAIL stall_resume got %b want %b", b0[7:0], {1'b1, 2'b11, 5'b11000});
        end
        checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL stall_busy_end got %b want 0", busy[0]); end
    endtask

    initial begin
        test_reset();
        test_frame_p0();
        test_parity();
        test_back_to_back();
        test_reset_mid_frame();
        test_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
